// File: rtl/theremin_pkg.sv
// Shared types and constants for the theremin ranging path.
// The counter width helper sizes a counter that runs 0 .. n_states-1.
package theremin_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      DONE
   } ranger_state_e;

   localparam int unsigned NUM_W = 7;
   localparam logic [NUM_W-1:0] NUM_MAX = 7'd127;

   function automatic int cnt_w(input int unsigned n_states);
      return (n_states < 2) ? 1 : $clog2(n_states);
   endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for an asynchronous sensor level, followed by a
// registered edge detector. echo_s is the conditioned level aligned with rise/fall.
module echo_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic echo_s,
   output logic rise,
   output logic fall
);

   logic sync1;
   logic sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         echo_s <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync1  <= din;
         sync2  <= sync1;
         echo_s <= sync2;
         rise   <= sync2 & ~echo_s;
         fall   <= ~sync2 & echo_s;
      end
   end

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ranging front end: periodic trigger, echo width timing and
// conversion to a saturated 7-bit distance in cm for the tone divider.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | trig low, waiting for the period counter (or first trigger)
//   TRIG      | trig high for TRIG_CYC cycles, measurement counters cleared
//   WAIT_RISE | waiting for an echo rising edge, timeout counter running
//   MEASURE   | echo high, sub-counter ticks cm counter, timeout running
//   DONE      | one cycle with valid high, then back to IDLE
module hcsr04_ranger import theremin_pkg::*; #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned TRIG_US    = 10,
   parameter int unsigned PERIOD_MS  = 60,
   parameter int unsigned TIMEOUT_US = 25_000,
   parameter int unsigned US_PER_CM  = 58
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             echo,
   output logic             trig,
   output logic [NUM_W-1:0] num,
   output logic             valid,
   output logic             timeout
);

   localparam int unsigned CYC_US     = CLK_HZ / 1_000_000;
   localparam int unsigned TRIG_CYC   = TRIG_US * CYC_US;
   localparam int unsigned PERIOD_CYC = PERIOD_MS * 1000 * CYC_US;
   localparam int unsigned TO_CYC     = TIMEOUT_US * CYC_US;
   localparam int unsigned CM_CYC     = US_PER_CM * CYC_US;

   localparam int PC_W  = cnt_w(PERIOD_CYC);
   localparam int TO_W  = cnt_w(TO_CYC);
   localparam int SUB_W = cnt_w(CM_CYC);

   localparam logic [PC_W-1:0]  PC_LAST   = PC_W'(PERIOD_CYC - 1);
   localparam logic [PC_W-1:0]  TRIG_LAST = PC_W'(TRIG_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);
   localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CM_CYC - 1);

   ranger_state_e    state;
   logic             first_trig;
   logic [PC_W-1:0]  period_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [SUB_W-1:0] sub_cnt;
   logic [NUM_W-1:0] cm_cnt;

   logic             echo_s;
   logic             rise;
   logic             fall;

   echo_sync u_echo_sync (
      .clk    (clk),
      .rst    (rst),
      .din    (echo),
      .echo_s (echo_s),
      .rise   (rise),
      .fall   (fall)
   );

   logic             to_done;
   logic             sub_wrap;
   logic [NUM_W-1:0] cm_inc;
   logic [NUM_W-1:0] cm_fin;

   // cm_fin includes the tick of the cycle in which fall is seen.
   assign to_done  = (to_cnt == TO_LAST);
   assign sub_wrap = (sub_cnt == SUB_LAST);
   assign cm_inc   = (cm_cnt == NUM_MAX) ? cm_cnt : cm_cnt + 1'b1;
   assign cm_fin   = sub_wrap ? cm_inc : cm_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         first_trig <= 1'b1;
         trig       <= 1'b0;
         num        <= '0;
         valid      <= 1'b0;
         timeout    <= 1'b0;
         period_cnt <= '0;
         to_cnt     <= '0;
         sub_cnt    <= '0;
         cm_cnt     <= '0;
      end else begin
         valid      <= 1'b0;
         period_cnt <= (period_cnt == PC_LAST) ? '0 : period_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (first_trig || period_cnt == PC_LAST) begin
                  state      <= TRIG;
                  trig       <= 1'b1;
                  first_trig <= 1'b0;
                  period_cnt <= '0;
               end
            end
            TRIG: begin
               to_cnt  <= '0;
               sub_cnt <= '0;
               cm_cnt  <= '0;
               if (period_cnt == TRIG_LAST) begin
                  trig  <= 1'b0;
                  state <= WAIT_RISE;
               end
            end
            WAIT_RISE: begin
               to_cnt <= to_cnt + 1'b1;
               if (to_done) begin
                  state   <= DONE;
                  num     <= NUM_MAX;
                  timeout <= 1'b1;
                  valid   <= 1'b1;
               end else if (rise && echo_s) begin
                  state <= MEASURE;
               end
            end
            MEASURE: begin
               if (!to_done) to_cnt <= to_cnt + 1'b1;
               sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
               if (sub_wrap) cm_cnt <= cm_inc;
               if (fall) begin
                  state   <= DONE;
                  num     <= cm_fin;
                  timeout <= 1'b0;
                  valid   <= 1'b1;
               end else if (to_done) begin
                  state   <= DONE;
                  num     <= NUM_MAX;
                  timeout <= 1'b1;
                  valid   <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger at a 1 MHz clock. Period and timeout are
// shortened (9 ms / 8.5 ms) so that six measurements fit in a short run.
module tb_hcsr04_ranger;

   localparam int PERIOD_CYC = 9000;
   localparam int TRIG_CYC   = 10;
   localparam int TO_CYC     = 8500;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       echo = 1'b0;
   logic       trig;
   logic [6:0] num;
   logic       valid;
   logic       timeout;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_rise = 0;
   logic [7:0] sb_q[$];

   hcsr04_ranger #(
      .CLK_HZ     (1_000_000),
      .TRIG_US    (10),
      .PERIOD_MS  (9),
      .TIMEOUT_US (8500),
      .US_PER_CM  (58)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .echo    (echo),
      .trig    (trig),
      .num     (num),
      .valid   (valid),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every valid strobe pops one expected {timeout, num}.
   always @(posedge clk) begin
      logic [7:0] exp_r;
      #1;
      if (valid === 1'b1) begin
         n_cmp++;
         assert (sb_q.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_valid observed num=%0d timeout=%0b expected no strobe", num, timeout);
         end
         if (sb_q.size() != 0) begin
            exp_r = sb_q.pop_front();
            n_cmp++;
            assert ({timeout, num} === exp_r) else begin
               n_err++;
               $error("FAIL sb_result observed num=%0d timeout=%0b expected num=%0d timeout=%0b",
                      num, timeout, exp_r[6:0], exp_r[7]);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_trig(input logic lvl, input int max_cyc, output int waited);
      waited = 0;
      while (trig !== lvl && waited < max_cyc) begin
         tick(1);
         waited++;
      end
      check_int("trig_wait", int'(trig), int'(lvl));
   endtask

   task automatic wait_valid(input int max_cyc, output int waited);
      waited = 0;
      while (valid !== 1'b1 && waited < max_cyc) begin
         tick(1);
         waited++;
      end
      check_int("valid_wait", int'(valid), 1);
   endtask

   // One trigger period: check trigger timing, drive an echo, expect one result.
   task automatic measure(input string tag, input bit first, input bit stale,
                          input int high, input int exp_n, input bit exp_to);
      int w;
      int t_fall;
      wait_trig(1'b1, PERIOD_CYC + 20, w);
      if (first) check_int({tag, "_first_trig_delay"}, w, 1);
      else       check_int({tag, "_trig_spacing"}, cyc - last_rise, PERIOD_CYC);
      last_rise = cyc;
      wait_trig(1'b0, TRIG_CYC + 20, w);
      check_int({tag, "_trig_width"}, w, TRIG_CYC);
      t_fall = cyc;
      if (stale) begin
         tick(50);
         echo = 1'b0;
         tick(50);
      end else begin
         tick(100);
      end
      sb_q.push_back({exp_to, 7'(exp_n)});
      if (high > 0) begin
         echo = 1'b1;
         tick(high);
         echo = 1'b0;
         wait_valid(20, w);
         check_int({tag, "_fall_to_valid"}, w, 4);
      end else begin
         wait_valid(TO_CYC + 20, w);
         check_int({tag, "_timeout_latency"}, cyc - t_fall, TO_CYC);
      end
      tick(1);
   endtask

   initial begin
      int w;
      int strobes;
      rst  = 1'b1;
      echo = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check_int("reset_outputs", int'({trig, valid, num}), 0);
      end
      rst = 1'b0;

      measure("nominal", 1'b1, 1'b0, 1160, 20, 1'b0);
      tick(1000);
      check_int("num_hold", int'(num), 20);
      check_int("valid_idle", int'(valid), 0);

      measure("round_down", 1'b0, 1'b0, 1159, 19, 1'b0);
      measure("saturate", 1'b0, 1'b0, 8000, 127, 1'b0);
      measure("no_echo", 1'b0, 1'b0, 0, 127, 1'b1);

      echo = 1'b1;
      measure("stale", 1'b0, 1'b1, 580, 10, 1'b0);

      wait_trig(1'b1, PERIOD_CYC + 20, w);
      check_int("rstmid_trig_spacing", cyc - last_rise, PERIOD_CYC);
      wait_trig(1'b0, TRIG_CYC + 20, w);
      tick(100);
      echo = 1'b1;
      tick(300);
      rst  = 1'b1;
      echo = 1'b0;
      tick(1);
      check_int("rstmid_num", int'(num), 0);
      check_int("rstmid_valid", int'(valid), 0);
      check_int("rstmid_trig", int'(trig), 0);
      rst = 1'b0;
      tick(1);
      check_int("rstmid_fresh_trig", int'(trig), 1);
      strobes = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (valid === 1'b1) strobes++;
      end
      check_int("rstmid_no_strobe", strobes, 0);
      check_int("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
